// File: rtl/e1ofn_rtl_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : e1ofn_rtl_bridge
//  Description : Clocked bridge between e1ofN delay-insensitive channels and
//                synchronous valid/ready RTL. One receive path (channel ->
//                core) and one send path (core -> channel), each running a
//                four-phase return-to-zero handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module e1ofn_rtl_bridge #(
    parameter  int M = 9,
    parameter  int N = 2,
    localparam int L = $clog2(N),
    localparam int W = M * L
) (
    input  logic             CLK,
    input  logic             _RESET,
    // receive channel (asynchronous side)
    input  logic [M*N-1:0]   rx_rails_i,
    output logic             rx_e_o,
    // receive side towards the core
    output logic [W-1:0]     rcv_data_o,
    output logic             rcv_valid_o,
    input  logic             rcv_ready_i,
    // send side from the core
    input  logic [W-1:0]     snd_data_i,
    input  logic             snd_valid_i,
    output logic             snd_ready_o,
    // send channel (asynchronous side)
    output logic [M*N-1:0]   tx_rails_o,
    input  logic             tx_e_i
);

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RTZ = 1'b1} rx_state_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAITLO = 2'd1, S_WAITHI = 2'd2} tx_state_t;

    rx_state_t        rx_state, rx_next;
    tx_state_t        tx_state, tx_next;
    logic [M*N-1:0]   rx_sync1, rx_sync2;
    logic             tx_e_sync1, tx_e_sync2;
    logic             rx_complete, rx_neutral, rx_capture;
    logic [W-1:0]     rx_decoded;
    logic [M*N-1:0]   tx_encoded;
    logic             tx_load;

    // Position of the single high rail in a digit (only meaningful when one-hot).
    function automatic logic [L-1:0] rail_index(input logic [N-1:0] r);
        logic [L-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) idx = L'(i);
        end
        return idx;
    endfunction

    // Two-flop synchronisers: the raw rails and enable reach nothing else.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rx_sync1   <= '0;
            rx_sync2   <= '0;
            tx_e_sync1 <= 1'b0;
            tx_e_sync2 <= 1'b0;
        end else begin
            rx_sync1   <= rx_rails_i;
            rx_sync2   <= rx_sync1;
            tx_e_sync1 <= tx_e_i;
            tx_e_sync2 <= tx_e_sync1;
        end
    end

    // Token completion check and decode; a digit with several rails high is not valid.
    always_comb begin
        rx_complete = 1'b1;
        rx_decoded  = '0;
        for (int d = 0; d < M; d++) begin
            if (!$onehot(rx_sync2[d*N +: N])) rx_complete = 1'b0;
            rx_decoded[d*L +: L] = rail_index(rx_sync2[d*N +: N]);
        end
        rx_neutral = (rx_sync2 == '0);
    end

    // Binary to one-hot-per-digit encode of the core's outgoing token.
    always_comb begin
        tx_encoded = '0;
        for (int d = 0; d < M; d++) begin
            for (int v = 0; v < N; v++) begin
                tx_encoded[d*N + v] = (snd_data_i[d*L +: L] == L'(v));
            end
        end
    end

    // RX next state: capture only into an empty buffer, then wait for neutral.
    always_comb begin
        rx_next    = rx_state;
        rx_capture = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_complete && !rcv_valid_o) begin
                    rx_capture = 1'b1;
                    rx_next    = R_RTZ;
                end
            end
            R_RTZ: begin
                if (rx_neutral) rx_next = R_IDLE;
            end
            default: rx_next = R_IDLE;
        endcase
    end

    // RX state, enable and one-entry receive buffer.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rx_state    <= R_IDLE;
            rx_e_o      <= 1'b1;
            rcv_valid_o <= 1'b0;
            rcv_data_o  <= '0;
        end else begin
            rx_state <= rx_next;
            rx_e_o   <= (rx_next == R_IDLE);
            if (rx_capture) begin
                rcv_valid_o <= 1'b1;
                rcv_data_o  <= rx_decoded;
            end else if (rcv_valid_o && rcv_ready_i) begin
                rcv_valid_o <= 1'b0;
            end
        end
    end

    // TX next state: load on handshake, drop rails on enable low, rearm on enable high.
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (snd_valid_i && snd_ready_o) begin
                    tx_load = 1'b1;
                    tx_next = S_WAITLO;
                end
            end
            S_WAITLO: begin
                if (!tx_e_sync2) tx_next = S_WAITHI;
            end
            S_WAITHI: begin
                if (tx_e_sync2) tx_next = S_IDLE;
            end
            default: tx_next = S_IDLE;
        endcase
    end

    // TX state, registered rails, and ready (uses the enable value arriving next cycle).
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            tx_state    <= S_IDLE;
            tx_rails_o  <= '0;
            snd_ready_o <= 1'b0;
        end else begin
            tx_state    <= tx_next;
            snd_ready_o <= (tx_next == S_IDLE) && tx_e_sync1;
            if (tx_load)
                tx_rails_o <= tx_encoded;
            else if (tx_next != S_WAITLO)
                tx_rails_o <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e1ofn_rtl_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e1ofn_rtl_bridge
//  Description : Directed self-checking bench for e1ofn_rtl_bridge
//                (M=9,N=2 main instance; M=3,N=4 loopback instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_e1ofn_rtl_bridge;

    logic        clk;
    logic        rst_n;

    // main instance, M=9 N=2
    logic [17:0] a_rx_rails;
    logic        a_rx_e;
    logic [8:0]  a_rcv_data;
    logic        a_rcv_valid;
    logic        a_rcv_ready;
    logic [8:0]  a_snd_data;
    logic        a_snd_valid;
    logic        a_snd_ready;
    logic [17:0] a_tx_rails;
    logic        a_tx_e;

    // loopback instance, M=3 N=4
    logic [11:0] b_rails;
    logic        b_e;
    logic [5:0]  b_rcv_data;
    logic        b_rcv_valid;
    logic        b_rcv_ready;
    logic [5:0]  b_snd_data;
    logic        b_snd_valid;
    logic        b_snd_ready;

    int checks_total  = 0;
    int checks_passed = 0;

    e1ofn_rtl_bridge #(.M(9), .N(2)) dut_a (
        .CLK         (clk),
        ._RESET      (rst_n),
        .rx_rails_i  (a_rx_rails),
        .rx_e_o      (a_rx_e),
        .rcv_data_o  (a_rcv_data),
        .rcv_valid_o (a_rcv_valid),
        .rcv_ready_i (a_rcv_ready),
        .snd_data_i  (a_snd_data),
        .snd_valid_i (a_snd_valid),
        .snd_ready_o (a_snd_ready),
        .tx_rails_o  (a_tx_rails),
        .tx_e_i      (a_tx_e)
    );

    e1ofn_rtl_bridge #(.M(3), .N(4)) dut_b (
        .CLK         (clk),
        ._RESET      (rst_n),
        .rx_rails_i  (b_rails),
        .rx_e_o      (b_e),
        .rcv_data_o  (b_rcv_data),
        .rcv_valid_o (b_rcv_valid),
        .rcv_ready_i (b_rcv_ready),
        .snd_data_i  (b_snd_data),
        .snd_valid_i (b_snd_valid),
        .snd_ready_o (b_snd_ready),
        .tx_rails_o  (b_rails),
        .tx_e_i      (b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dual-rail encode for N=2: bit b of digit d -> rail 2d+b
    function automatic logic [17:0] enc2(input logic [8:0] v);
        logic [17:0] r;
        r = '0;
        for (int d = 0; d < 9; d++) r[2*d + (v[d] ? 1 : 0)] = 1'b1;
        return r;
    endfunction

    task automatic consume_a();
        a_rcv_ready = 1'b1;
        tick();
        a_rcv_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_rx_rails  = '0;
        a_rcv_ready = 1'b0;
        a_snd_data  = '0;
        a_snd_valid = 1'b0;
        a_tx_e      = 1'b0;
        b_rcv_ready = 1'b0;
        b_snd_data  = '0;
        b_snd_valid = 1'b0;
        tick(); tick();

        // reset state
        check("rst_rx_e",      32'(a_rx_e),      32'd1);
        check("rst_rcv_valid", 32'(a_rcv_valid), 32'd0);
        check("rst_rcv_data",  32'(a_rcv_data),  32'd0);
        check("rst_tx_rails",  32'(a_tx_rails),  32'd0);
        check("rst_snd_ready", 32'(a_snd_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic receive with 3-cycle latency
        a_rx_rails = enc2(9'h1A5);
        tick(); tick();
        check("rx_lat_early", 32'(a_rcv_valid), 32'd0);
        tick();
        check("rx_lat_valid", 32'(a_rcv_valid), 32'd1);
        check("rx_data_1a5",  32'(a_rcv_data),  32'h1A5);
        check("rx_e_low",     32'(a_rx_e),      32'd0);
        a_rx_rails = '0;
        for (int i = 0; i < 20 && !a_rx_e; i++) tick();
        check("rx_e_rearm",   32'(a_rx_e),      32'd1);

        // 2: backpressure, second token waits for the consume
        a_rx_rails = enc2(9'h05A);
        repeat (6) tick();
        check("bp_rx_e_high", 32'(a_rx_e),      32'd1);
        check("bp_valid_held",32'(a_rcv_valid), 32'd1);
        check("bp_data_held", 32'(a_rcv_data),  32'h1A5);
        consume_a();
        check("bp_consumed",  32'(a_rcv_valid), 32'd0);
        tick();
        check("bp_second_vld",32'(a_rcv_valid), 32'd1);
        check("bp_second_dat",32'(a_rcv_data),  32'h05A);
        a_rx_rails = '0;
        for (int i = 0; i < 20 && !a_rx_e; i++) tick();
        consume_a();

        // 4: digit 4 with both rails high is not a token
        a_rx_rails = enc2(9'h0C3) | (18'h3 << 8);
        repeat (6) tick();
        check("bad_digit_rx_e",  32'(a_rx_e),      32'd1);
        check("bad_digit_valid", 32'(a_rcv_valid), 32'd0);
        a_rx_rails = enc2(9'h0C3);
        for (int i = 0; i < 20 && !a_rcv_valid; i++) tick();
        check("fixed_digit_vld", 32'(a_rcv_valid), 32'd1);
        check("fixed_digit_dat", 32'(a_rcv_data),  32'h0C3);
        a_rx_rails = '0;
        for (int i = 0; i < 20 && !a_rx_e; i++) tick();
        consume_a();

        // 3: send 0x0F3
        a_tx_e = 1'b1;
        for (int i = 0; i < 20 && !a_snd_ready; i++) tick();
        check("tx_ready_up", 32'(a_snd_ready), 32'd1);
        a_snd_data  = 9'h0F3;
        a_snd_valid = 1'b1;
        tick();
        a_snd_valid = 1'b0;
        check("tx_rails_0f3",   32'(a_tx_rails),  32'h1AA5A);
        check("tx_ready_drop",  32'(a_snd_ready), 32'd0);
        repeat (4) tick();
        check("tx_rails_hold",  32'(a_tx_rails),  32'h1AA5A);
        a_tx_e = 1'b0;
        for (int i = 0; i < 20 && a_tx_rails != '0; i++) tick();
        check("tx_rails_rtz",   32'(a_tx_rails),  32'd0);
        check("tx_ready_waithi",32'(a_snd_ready), 32'd0);
        a_tx_e = 1'b1;
        for (int i = 0; i < 20 && !a_snd_ready; i++) tick();
        check("tx_ready_again", 32'(a_snd_ready), 32'd1);

        // 5: reset in S_WAITLO and R_RTZ
        a_snd_data  = 9'h155;
        a_snd_valid = 1'b1;
        tick();
        a_snd_valid = 1'b0;
        check("pre_rst_tx_rails", 32'(a_tx_rails), 32'(enc2(9'h155)));
        a_rx_rails = enc2(9'h0AA);
        for (int i = 0; i < 20 && !a_rcv_valid; i++) tick();
        check("pre_rst_rx_e", 32'(a_rx_e), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_rails",  32'(a_tx_rails),  32'd0);
        check("mid_rst_rx_e",      32'(a_rx_e),      32'd1);
        check("mid_rst_rcv_valid", 32'(a_rcv_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !a_rcv_valid; i++) tick();
        check("retake_valid", 32'(a_rcv_valid), 32'd1);
        check("retake_data",  32'(a_rcv_data),  32'h0AA);
        a_rx_rails = '0;
        for (int i = 0; i < 20 && !a_rx_e; i++) tick();
        consume_a();

        // 6: M=3 N=4 loopback of 6'h2D
        for (int i = 0; i < 20 && !b_snd_ready; i++) tick();
        check("lb_ready", 32'(b_snd_ready), 32'd1);
        b_snd_data  = 6'h2D;
        b_snd_valid = 1'b1;
        tick();
        b_snd_valid = 1'b0;
        check("lb_rails_2d", 32'(b_rails), 32'h482);
        for (int i = 0; i < 20 && !b_rcv_valid; i++) tick();
        check("lb_rcv_valid", 32'(b_rcv_valid), 32'd1);
        check("lb_rcv_data",  32'(b_rcv_data),  32'h2D);
        for (int i = 0; i < 30 && !b_snd_ready; i++) tick();
        check("lb_cycle_done", 32'(b_snd_ready), 32'd1);
        check("lb_rails_rtz",  32'(b_rails),     32'd0);
        b_rcv_ready = 1'b1;
        tick();
        b_rcv_ready = 1'b0;
        check("lb_consumed", 32'(b_rcv_valid), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
